// File: rtl/mem_access.sv
// mem_access -- memory stage of the 64-bit pipeline.
//   Issues loads/stores to data memory over a registered req/ack handshake,
//   stalls upstream stages while an access is outstanding, aborts an access
//   that sees no ack within TIMEOUT cycles, and resolves the branch decision.
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   valid_M, memRead_M, memWrite_M, branch_M, zero_M   decoded instruction info
//   aluResult_M, writeData_M                          address / store data
//   dm_req, dm_we, dm_addr, dm_wdata                  registered memory request
//   dm_ack, dm_rdata                                  memory completion / read data
//   readData_M   last load result      done_M   one-cycle completion pulse
//   stall_M      upstream hold         PCSrc_M  take branch
//   err_M        sticky fault (illegal op, misaligned, timeout)
module mem_access #(
  parameter int N       = 64,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_M,
  input  logic         memRead_M,
  input  logic         memWrite_M,
  input  logic         branch_M,
  input  logic         zero_M,
  input  logic [N-1:0] aluResult_M,
  input  logic [N-1:0] writeData_M,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic         dm_ack,
  input  logic [N-1:0] dm_rdata,
  output logic [N-1:0] readData_M,
  output logic         done_M,
  output logic         stall_M,
  output logic         PCSrc_M,
  output logic         err_M
);

  localparam int            AW   = $clog2(N / 8);
  localparam int            TW   = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [TW-1:0] r_timer;
  logic          w_mem_op, w_illegal, w_misaligned, w_start;

  assign w_mem_op     = valid_M & (memRead_M ^ memWrite_M);
  assign w_illegal    = valid_M & memRead_M & memWrite_M;
  assign w_misaligned = w_mem_op & (|aluResult_M[AW-1:0]);
  assign w_start      = w_mem_op & ~w_misaligned;

  assign PCSrc_M = valid_M & branch_M & zero_M;

  always_comb begin
    w_next  = r_state;
    stall_M = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall_M = w_start;
        if (w_start) w_next = S_WAIT;
      end
      S_WAIT: begin
        stall_M = 1'b1;
        if (dm_ack || r_timer == TMAX) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Upstream must never be held while the pipeline is being reset.
    if (reset) stall_M = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      dm_addr    <= '0;
      dm_wdata   <= '0;
      readData_M <= '0;
      done_M     <= 1'b0;
      err_M      <= 1'b0;
    end else begin
      r_state <= w_next;
      // DONE is only reachable from WAIT and lasts one cycle, so this is a pulse.
      done_M  <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            dm_addr  <= aluResult_M;
            dm_wdata <= writeData_M;
            dm_we    <= memWrite_M;
            dm_req   <= 1'b1;
            r_timer  <= '0;
          end else if (w_illegal || w_misaligned) begin
            err_M <= 1'b1;
          end
        end
        S_WAIT: begin
          if (dm_ack) begin
            dm_req <= 1'b0;
            if (!dm_we) readData_M <= dm_rdata;
          end else if (r_timer == TMAX) begin
            dm_req     <= 1'b0;
            err_M      <= 1'b1;
            readData_M <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
